fb_writer: RTL and testbench



---
 rtl/fb_pkg.sv | 25 ++
 rtl/fb_addr_cnt.sv | 42 ++++
 rtl/fb_writer.sv | 138 +++++++++++++
 tb/tb_fb_writer.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/fb_pkg.sv
// Shared definitions for the framebuffer write path.
// Holds the framebuffer geometry, the pixel width, the command opcode encodings
// and the write-controller FSM state encoding.
// Addresses are {y, x}, so one row occupies FB_W consecutive addresses.
package fb_pkg;

  localparam int FB_W   = 64;          // framebuffer width in pixels (power of two)
  localparam int FB_H   = 64;          // framebuffer height in pixels (power of two)
  localparam int X_W    = 6;           // log2(FB_W)
  localparam int Y_W    = 6;           // log2(FB_H)
  localparam int ADDR_W = X_W + Y_W;   // address = {y, x}
  localparam int DATA_W = 8;           // grey pixel width

  localparam logic [1:0] OP_PIXEL = 2'b00;
  localparam logic [1:0] OP_HSPAN = 2'b01;
  localparam logic [1:0] OP_FILL  = 2'b10;
  localparam logic [1:0] OP_RSVD  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SPAN = 2'd1,
    ST_FILL = 2'd2
  } fb_state_t;

endpackage

// File: rtl/fb_addr_cnt.sv
// Loadable address counter shared by the span and fill sequences.
// Ports:
//   clock, reset     system clock, asynchronous active-low reset
//   load             load start address and remaining write count
//   load_addr        address of the next write after the one issued at load time
//   load_cnt         number of writes still to issue after load
//   step             advance one address (one write issued this cycle)
//   addr             address of the next write to issue
//   done             the write about to be issued is the final one
module fb_addr_cnt
  import fb_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              load,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [ADDR_W-1:0] load_cnt,
  input  logic              step,
  output logic [ADDR_W-1:0] addr,
  output logic              done
);

  logic [ADDR_W-1:0] addr_reg;
  logic [ADDR_W-1:0] cnt_reg;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      addr_reg <= '0;
      cnt_reg  <= '0;
    end else if (load) begin
      addr_reg <= load_addr;
      cnt_reg  <= load_cnt;
    end else if (step && (cnt_reg != '0)) begin
      addr_reg <= addr_reg + ADDR_W'(1);
      cnt_reg  <= cnt_reg - ADDR_W'(1);
    end
  end

  assign addr = addr_reg;
  assign done = (cnt_reg == ADDR_W'(1));

endmodule

// File: rtl/fb_writer.sv
// Write-side controller for the video framebuffer.
// Accepts PIXEL / HSPAN / FILL commands over valid/ready and issues one
// framebuffer write per cycle. The first write of every command is issued at
// the acceptance edge itself; any remaining writes of a span or fill are
// sequenced by fb_addr_cnt.
// Ports:
//   clock, reset            system clock, asynchronous active-low reset
//   cmd_valid/cmd_ready     command handshake
//   cmd_op                  00 PIXEL, 01 HSPAN, 10 FILL, 11 reserved (no-op)
//   cmd_x, cmd_y            start column and row
//   cmd_len                 span length 0..FB_W (clipped at the row end)
//   cmd_color               pixel value
//   wr_en/wr_addr/wr_data   framebuffer write port
//   busy                    multi-cycle command in progress
module fb_writer
  import fb_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [X_W-1:0]    cmd_x,
  input  logic [Y_W-1:0]    cmd_y,
  input  logic [X_W:0]      cmd_len,
  input  logic [DATA_W-1:0] cmd_color,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              busy
);

  localparam logic [X_W:0]      ROW_LEN   = (X_W+1)'(FB_W);
  localparam logic [X_W:0]      ONE_COL   = (X_W+1)'(1);
  localparam logic [ADDR_W-1:0] FILL_LAST = ADDR_W'(FB_W * FB_H - 1);

  fb_state_t         state_reg;
  logic [DATA_W-1:0] color_reg;

  logic              accept;
  logic [X_W:0]      span_room;
  logic [X_W:0]      span_n;
  logic              span_multi;
  logic              cnt_load;
  logic [ADDR_W-1:0] cnt_load_addr;
  logic [ADDR_W-1:0] cnt_load_cnt;
  logic [ADDR_W-1:0] cnt_addr;
  logic              cnt_done;

  assign accept = cmd_valid && cmd_ready;

  // Columns left in the row; one bit wider than x so FB_W itself fits.
  assign span_room  = ROW_LEN - {1'b0, cmd_x};
  assign span_n     = (cmd_len < span_room) ? cmd_len : span_room;
  assign span_multi = (cmd_op == OP_HSPAN) && (span_n > ONE_COL);

  // The acceptance edge issues the first write, so the counter starts one
  // address further on with one write fewer to go.
  assign cnt_load      = accept && (span_multi || (cmd_op == OP_FILL));
  assign cnt_load_addr = (cmd_op == OP_FILL) ? ADDR_W'(1)
                                             : ({cmd_y, cmd_x} + ADDR_W'(1));
  assign cnt_load_cnt  = (cmd_op == OP_FILL) ? FILL_LAST
                                             : ADDR_W'(span_n - ONE_COL);

  fb_addr_cnt u_addr_cnt (
    .clock     (clock),
    .reset     (reset),
    .load      (cnt_load),
    .load_addr (cnt_load_addr),
    .load_cnt  (cnt_load_cnt),
    .step      (state_reg != ST_IDLE),
    .addr      (cnt_addr),
    .done      (cnt_done)
  );

  // cmd_ready and busy are registered from the next state, so on the cycle
  // carrying the final write of a sequence the controller already shows idle.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_reg <= ST_IDLE;
      color_reg <= '0;
      wr_en     <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
      busy      <= 1'b0;
      cmd_ready <= 1'b0;
    end else begin
      wr_en <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          cmd_ready <= 1'b1;
          if (accept) begin
            color_reg <= cmd_color;
            case (cmd_op)
              OP_PIXEL: begin
                wr_en   <= 1'b1;
                wr_addr <= {cmd_y, cmd_x};
                wr_data <= cmd_color;
              end
              OP_HSPAN: begin
                if (span_n != '0) begin
                  wr_en   <= 1'b1;
                  wr_addr <= {cmd_y, cmd_x};
                  wr_data <= cmd_color;
                end
                if (span_multi) begin
                  state_reg <= ST_SPAN;
                  busy      <= 1'b1;
                  cmd_ready <= 1'b0;
                end
              end
              OP_FILL: begin
                wr_en     <= 1'b1;
                wr_addr   <= '0;
                wr_data   <= cmd_color;
                state_reg <= ST_FILL;
                busy      <= 1'b1;
                cmd_ready <= 1'b0;
              end
              default: ;  // reserved op: consumed without effect
            endcase
          end
        end
        default: begin  // ST_SPAN, ST_FILL
          wr_en   <= 1'b1;
          wr_addr <= cnt_addr;
          wr_data <= color_reg;
          if (cnt_done) begin
            state_reg <= ST_IDLE;
            busy      <= 1'b0;
            cmd_ready <= 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fb_writer.sv
// Self-checking bench for fb_writer.
// A driver issues directed and random commands; for each accepted command a
// reference model pushes the expected writes (cycle, address, colour) into a
// scoreboard queue and records when the controller becomes idle again. A
// separate monitor compares the write port, cmd_ready and busy every cycle.
module tb_fb_writer;
  import fb_pkg::*;

  logic              clock = 1'b0;
  logic              reset = 1'b0;
  logic              cmd_valid = 1'b0;
  logic              cmd_ready;
  logic [1:0]        cmd_op = 2'b00;
  logic [X_W-1:0]    cmd_x = '0;
  logic [Y_W-1:0]    cmd_y = '0;
  logic [X_W:0]      cmd_len = '0;
  logic [DATA_W-1:0] cmd_color = '0;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              busy;

  fb_writer dut (
    .clock     (clock),
    .reset     (reset),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_x     (cmd_x),
    .cmd_y     (cmd_y),
    .cmd_len   (cmd_len),
    .cmd_color (cmd_color),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .busy      (busy)
  );

  always #5 clock = ~clock;

  typedef struct {
    int cyc;
    int addr;
    int data;
  } wr_t;

  wr_t exp_q[$];
  int  cyc        = 0;   // bumped 1 time unit after every rising edge
  int  busy_until = 0;   // model: first cycle in which the controller is idle again
  int  n_checks   = 0;
  int  n_pass     = 0;
  int  n_cmds     = 0;
  int  n_fills    = 0;
  bit  exp_we;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Reference model: command semantics written directly from the rules.
  // k is the cycle in which the command is accepted.
  task automatic model(input int k, input int op, input int x, input int y,
                       input int len, input int color);
    int n;
    case (op)
      0: exp_q.push_back('{k + 1, y * FB_W + x, color});
      1: begin
        n = (len < FB_W - x) ? len : FB_W - x;
        for (int i = 0; i < n; i++) exp_q.push_back('{k + 1 + i, y * FB_W + x + i, color});
        if (n > 1) busy_until = k + n;
      end
      2: begin
        for (int i = 0; i < FB_W * FB_H; i++) exp_q.push_back('{k + 1 + i, i, color});
        busy_until = k + FB_W * FB_H;
      end
      default: ;
    endcase
  endtask

  // Present a command and hold it until the model says it is taken.
  task automatic issue(input int op, input int x, input int y, input int len,
                       input int color, output int acc);
    @(negedge clock);
    cmd_valid = 1'b1;
    cmd_op    = 2'(op);
    cmd_x     = X_W'(x);
    cmd_y     = Y_W'(y);
    cmd_len   = (X_W+1)'(len);
    cmd_color = DATA_W'(color);
    while (cyc < busy_until) @(negedge clock);
    acc = cyc;
    model(acc, op, x, y, len, color);
    n_cmds++;
    $display("cmd %0d: op=%0d x=%0d y=%0d len=%0d color=%02h accepted in cycle %0d",
             n_cmds, op, x, y, len, color, acc);
  endtask

  // Idle cycles with junk on the command fields.
  task automatic gap(input int n);
    repeat (n) begin
      @(negedge clock);
      cmd_valid = 1'b0;
      cmd_op    = 2'($urandom);
      cmd_x     = X_W'($urandom);
      cmd_y     = Y_W'($urandom);
      cmd_len   = (X_W+1)'($urandom);
      cmd_color = DATA_W'($urandom);
    end
  endtask

  // Monitor / scoreboard.
  initial begin
    forever begin
      @(posedge clock);
      #1;
      cyc++;
      if (reset) begin
        exp_we = (exp_q.size() > 0) && (exp_q[0].cyc == cyc);
        check("wr_en", wr_en, exp_we);
        if (exp_we) begin
          if (wr_en) begin
            check("wr_addr", wr_addr, exp_q[0].addr);
            check("wr_data", wr_data, exp_q[0].data);
          end
          void'(exp_q.pop_front());
        end
        check("cmd_ready", cmd_ready, cyc >= busy_until);
        check("busy", busy, cyc < busy_until);
      end
    end
  end

  // Driver.
  initial begin
    int acc;
    int r;
    int op;
    int waited;

    // Reset state while reset is held low.
    repeat (3) @(negedge clock);
    #1;
    check("rst_wr_en", wr_en, 0);
    check("rst_wr_addr", wr_addr, 0);
    check("rst_wr_data", wr_data, 0);
    check("rst_busy", busy, 0);
    check("rst_cmd_ready", cmd_ready, 0);
    @(negedge clock);
    reset = 1'b1;
    #1;
    check("ready_before_first_edge", cmd_ready, 0);

    // Directed cases.
    issue(0, 5, 3, 0, 8'hA5, acc);
    gap(2);
    issue(0, 0, 0, 0, 8'h11, acc);
    issue(0, 1, 0, 0, 8'h22, acc);
    issue(0, 63, 63, 0, 8'h33, acc);
    gap(2);
    issue(1, 60, 2, 10, 8'h3C, acc);   // clipped to 4 writes
    issue(1, 10, 4, 0, 8'h77, acc);    // zero length
    issue(1, 20, 5, 1, 8'h44, acc);    // single-pixel span
    issue(1, 0, 6, 64, 8'h55, acc);    // full row
    gap(1);
    issue(2, 9, 9, 9, 8'h00, acc);     // fill
    n_fills++;
    issue(0, 7, 7, 0, 8'h99, acc);     // held through the fill
    issue(3, 1, 1, 5, 8'hEE, acc);     // reserved
    gap(3);

    // Random traffic.
    for (int i = 0; i < 70; i++) begin
      r  = int'($urandom_range(0, 99));
      op = (r < 35) ? 0 : (r < 80) ? 1 : (r < 97) ? 3 : 2;
      if (op == 2 && n_fills >= 2) op = 1;
      if (op == 2) n_fills++;
      issue(op, int'($urandom_range(0, FB_W - 1)), int'($urandom_range(0, FB_H - 1)),
            int'($urandom_range(0, FB_W)), int'($urandom_range(0, 255)), acc);
      if ($urandom_range(0, 2) == 0) gap(int'($urandom_range(1, 3)));
    end

    // Reset in the middle of a fill, right after address 0x064 is written.
    issue(2, 0, 0, 0, 8'h5A, acc);
    gap(1);
    while (cyc < acc + 101) @(negedge clock);
    reset = 1'b0;
    #1;
    check("abort_wr_en", wr_en, 0);
    check("abort_busy", busy, 0);
    check("abort_cmd_ready", cmd_ready, 0);
    check("abort_wr_addr", wr_addr, 0);
    exp_q.delete();
    busy_until = 0;
    gap(2);
    @(negedge clock);
    reset = 1'b1;
    gap(20);
    issue(1, 30, 8, 3, 8'hC3, acc);
    gap(1);

    // Let outstanding expected writes drain.
    waited = 0;
    while (exp_q.size() > 0 && waited < 5000) begin
      @(negedge clock);
      waited++;
    end
    gap(2);
    check("queue_drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
